regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Write-port arbiter for the 64-bit integer register file, which has a single write port. It accepts writeback requests from three producers (ALU, load unit, FPU integer results) and grants one per cycle by round-robin. The granted write goes through one pipeline register that drives the register file's write address, data and enable directly. Writes targeting x0 are consumed without a write strobe.

## Interface
Parameters:
- DATA_WIDTH, 64, writeback data width
- ADDR_WIDTH, 5, register address width

Ports:
- in_Clk  input  1  clock; all state updates on rising edge
- in_Rst  input  1  asynchronous, active-high reset
- in_hold  input  1  when 1, no grants are issued this cycle (pipeline freeze)
- in_req  input  3  request per source: bit0 ALU, bit1 load unit, bit2 FPU
- in_addr_alu / in_addr_lsu / in_addr_fpu  input  ADDR_WIDTH each  destination register per source
- in_data_alu / in_data_lsu / in_data_fpu  input  DATA_WIDTH each  writeback data per source
- out_gnt  output  3  one-hot grant, combinational in the same cycle as the request
- out_writeAddr  output  ADDR_WIDTH  registered write address to the register file
- out_data  output  DATA_WIDTH  registered write data to the register file
- out_write_En  output  1  registered write enable to the register file
- out_prio  output  2  current round-robin pointer (0, 1 or 2), for debug/verification

## Operation
- Handshake: a source raises in_req[i] with address and data stable. It holds them until the cycle in which out_gnt[i]=1. The transfer completes in that cycle. The source may present a new request in the following cycle.
- Dropping a request before it is granted is illegal. The bench flags it; the RTL needs no defined behaviour for it.
- Grant: at most one bit of out_gnt is set. out_gnt=0 when in_hold=1 or in_req=0.
- Round-robin: search starts at index out_prio and wraps 2→0. The first requesting index wins.
- Pointer update: on a grant to index g, the pointer becomes (g+1) mod 3. With no grant, the pointer is unchanged. Pointer values 0..2 only; value 3 is unreachable and must decode as 0.
- Output stage, on each clock edge:
  - out_writeAddr and out_data load the granted source's address and data.
  - out_write_En = (grant this cycle) AND (granted address ≠ 0).
  - With no grant, out_write_En=0 and out_writeAddr/out_data hold their previous values.
- x0: the request is granted and the pointer advances, but out_write_En stays 0.
- in_hold has priority over all requests. It does not clear the output stage: a write already registered still completes on the next cycle.

## Timing
- Reset (asynchronous, in_Rst=1):
  - out_prio=0, out_write_En=0, out_writeAddr=0, out_data=0.
  - out_gnt=0 while in_Rst=1.
- Reset asserted mid-operation clears the pending output-stage write immediately; that write is lost.
- First grant is possible in the first cycle after in_Rst deasserts.
- Latency: request granted in cycle N → register file write strobe in cycle N+1 → data visible on register file read ports from cycle N+2.
- Throughput: one write per cycle under continuous requests. Each of k active sources is served at least once every k cycles; worst-case wait is 2 cycles.
- No same-address merging: two sources targeting the same register are written in grant order, and the later grant wins.

## Test plan
- Reset: assert in_Rst mid-write with out_write_En=1 → all outputs 0 asynchronously, out_prio=0. After release, a single in_req=001 with addr=5, data=0xA5 → out_gnt=001, then the next cycle out_write_En=1, out_writeAddr=5, out_data=0xA5.
- Round-robin: in_req=111 held continuously, with each source re-requesting after its grant → out_gnt sequence 001,010,100,001…; out_prio sequence 0,1,2,0.
- Pointer skip: out_prio=1, in_req=101 → out_gnt=100, out_prio becomes 0; next cycle in_req=001 → out_gnt=001.
- x0 write: LSU requests addr=0, data=0xFFFF → out_gnt=010, next cycle out_write_En=0, out_prio advances to 2.
- Hold: in_hold=1 for 3 cycles with in_req=011 → out_gnt=000, out_prio unchanged, out_write_En=0. A write registered in the cycle before hold still pulses once.
- Same address: ALU (addr=7, data=1) then FPU (addr=7, data=2) granted in consecutive cycles → two write pulses; the register file finally holds x7=2.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin write-port arbiter for the integer register file
//
// Purpose: picks one of three writeback producers (ALU, load unit, FPU) per
// cycle by round-robin and registers the winning address/data/enable as the
// register file write port. Writes to x0 are granted but never strobed.
//
// Ports:
//   in_Clk            clock, rising edge
//   in_Rst            asynchronous active-high reset
//   in_hold           pipeline freeze, suppresses all grants
//   in_req[2:0]       request per source (0 ALU, 1 LSU, 2 FPU)
//   in_addr_*         destination register per source
//   in_data_*         writeback data per source
//   out_gnt[2:0]      one-hot combinational grant
//   out_writeAddr     registered write address
//   out_data          registered write data
//   out_write_En      registered write enable
//   out_prio[1:0]     current round-robin pointer
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst,
  input  logic                  in_hold,
  input  logic [2:0]            in_req,
  input  logic [ADDR_WIDTH-1:0] in_addr_alu,
  input  logic [ADDR_WIDTH-1:0] in_addr_lsu,
  input  logic [ADDR_WIDTH-1:0] in_addr_fpu,
  input  logic [DATA_WIDTH-1:0] in_data_alu,
  input  logic [DATA_WIDTH-1:0] in_data_lsu,
  input  logic [DATA_WIDTH-1:0] in_data_fpu,
  output logic [2:0]            out_gnt,
  output logic [ADDR_WIDTH-1:0] out_writeAddr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_write_En,
  output logic [1:0]            out_prio
);

  logic [1:0]            prio_q, prio_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [1:0]            prio_eff;
  logic [1:0]            idx0, idx1, idx2;
  logic [1:0]            sel_idx;
  logic                  any_gnt;
  logic [2:0]            gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Modulo-3 increment; an out-of-range pointer also wraps to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    // Pointer value 3 is unreachable but must behave like 0.
    prio_eff = (prio_q == 2'd3) ? 2'd0 : prio_q;
    idx0     = prio_eff;
    idx1     = rr_next(idx0);
    idx2     = rr_next(idx1);

    any_gnt = 1'b0;
    sel_idx = 2'd0;
    // Reset masks grants so nothing is reported as transferred while
    // the output stage is being cleared.
    if (!in_Rst && !in_hold) begin
      if (in_req[idx0]) begin
        any_gnt = 1'b1;
        sel_idx = idx0;
      end else if (in_req[idx1]) begin
        any_gnt = 1'b1;
        sel_idx = idx1;
      end else if (in_req[idx2]) begin
        any_gnt = 1'b1;
        sel_idx = idx2;
      end
    end

    gnt = 3'b000;
    if (any_gnt) begin
      gnt[sel_idx] = 1'b1;
    end

    case (sel_idx)
      2'd1: begin
        sel_addr = in_addr_lsu;
        sel_data = in_data_lsu;
      end
      2'd2: begin
        sel_addr = in_addr_fpu;
        sel_data = in_data_fpu;
      end
      default: begin
        sel_addr = in_addr_alu;
        sel_data = in_data_alu;
      end
    endcase

    prio_d  = prio_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (any_gnt) begin
      prio_d  = rr_next(sel_idx);
      // x0 is hardwired zero: consume the request without a strobe.
      wen_d   = (sel_addr != '0);
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      prio_q  <= 2'd0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      prio_q  <= prio_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_gnt       = gnt;
  assign out_writeAddr = waddr_q;
  assign out_data      = wdata_q;
  assign out_write_En  = wen_q;
  assign out_prio      = prio_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic [2:0]    req;
  logic [AW-1:0] a_alu, a_lsu, a_fpu;
  logic [DW-1:0] d_alu, d_lsu, d_fpu;
  logic [2:0]    out_gnt;
  logic [AW-1:0] out_writeAddr;
  logic [DW-1:0] out_data;
  logic          out_write_En;
  logic [1:0]    out_prio;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .in_Clk        (clk),
    .in_Rst        (rst),
    .in_hold       (hold),
    .in_req        (req),
    .in_addr_alu   (a_alu),
    .in_addr_lsu   (a_lsu),
    .in_addr_fpu   (a_fpu),
    .in_data_alu   (d_alu),
    .in_data_lsu   (d_lsu),
    .in_data_fpu   (d_fpu),
    .out_gnt       (out_gnt),
    .out_writeAddr (out_writeAddr),
    .out_data      (out_data),
    .out_write_En  (out_write_En),
    .out_prio      (out_prio)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Source state: a pending request is held until granted.
  bit            pend[3];
  logic [AW-1:0] sa[3];
  logic [DW-1:0] sd[3];

  // Reference model state.
  int            m_prio;
  bit            m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] rf_m[32];
  logic [DW-1:0] rf_d[32];

  // Register file image fed by the DUT's write port.
  always @(posedge clk) begin
    if (out_write_En) rf_d[out_writeAddr] <= out_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    req   = {pend[2], pend[1], pend[0]};
    a_alu = sa[0]; a_lsu = sa[1]; a_fpu = sa[2];
    d_alu = sd[0]; d_lsu = sd[1]; d_fpu = sd[2];
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1;
    sa[i]   = a;
    sd[i]   = d;
  endtask

  // One clock cycle: check the registered stage, drive requests, check the
  // combinational grant, then advance the model past the coming edge.
  task automatic step(input bit h);
    int g;
    int idx;
    @(negedge clk);
    check("write_en", out_write_En, m_wen);
    check("write_addr", out_writeAddr, m_addr);
    check("write_data", out_data, m_data);
    check("prio", out_prio, m_prio);
    if (m_wen) rf_m[m_addr] = m_data;
    hold = h;
    drive_inputs();
    #1;
    g = -1;
    if (!h) begin
      for (int k = 0; k < 3; k++) begin
        idx = (m_prio + k) % 3;
        if (pend[idx] && g < 0) g = idx;
      end
    end
    check("gnt", out_gnt, (g < 0) ? 0 : (1 << g));
    if (g >= 0) begin
      m_prio  = (g + 1) % 3;
      m_addr  = sa[g];
      m_data  = sd[g];
      m_wen   = (sa[g] != 0);
      pend[g] = 1'b0;
    end else begin
      m_wen = 1'b0;
    end
  endtask

  // Assert reset a little after a rising edge, check the asynchronous
  // clear, then release on the following falling edge.
  task automatic reset_async();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_write_en", out_write_En, 0);
    check("rst_write_addr", out_writeAddr, 0);
    check("rst_write_data", out_data, 0);
    check("rst_prio", out_prio, 0);
    check("rst_gnt", out_gnt, 0);
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    hold = 1'b0;
    drive_inputs();
    m_prio = 0; m_wen = 1'b0; m_addr = '0; m_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_m[i] = '0;
      rf_d[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; sa[i] = '0; sd[i] = '0;
    end
    rst = 1'b1; hold = 1'b0;
    drive_inputs();
    m_prio = 0; m_wen = 1'b0; m_addr = '0; m_data = '0;
    reset_async();

    // Reset during a pending write, then a single ALU write to x5.
    set_src(1, 5'd3, 64'h33);
    step(0);
    reset_async();
    set_src(0, 5'd5, 64'hA5);
    step(0);
    step(0);
    check("x5_write_addr", out_writeAddr, 5);

    // Continuous requests from all three sources.
    reset_async();
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < 3; i++)
        if (!pend[i]) set_src(i, AW'(i + 10 + c), DW'(c * 3 + i));
      step(0);
    end
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    step(0);

    // Pointer skip from prio=1 with ALU and FPU requesting.
    reset_async();
    set_src(0, 5'd1, 64'h11);
    step(0);
    set_src(0, 5'd2, 64'h22);
    set_src(2, 5'd3, 64'h33);
    step(0);
    step(0);
    step(0);

    // x0 write from the load unit is consumed without a strobe.
    reset_async();
    set_src(0, 5'd4, 64'h44);
    step(0);
    set_src(1, 5'd0, 64'hFFFF);
    step(0);
    step(0);

    // Hold for three cycles right after a grant.
    set_src(0, 5'd6, 64'h66);
    step(0);
    set_src(0, 5'd8, 64'h88);
    set_src(1, 5'd9, 64'h99);
    step(1);
    step(1);
    step(1);
    step(0);
    step(0);
    step(0);

    // Same destination written twice; the later grant must win.
    reset_async();
    set_src(0, 5'd7, 64'd1);
    set_src(2, 5'd7, 64'd2);
    step(0);
    step(0);
    step(0);
    step(0);
    check("x7_final", rf_d[7], 64'd2);

    // Randomised traffic with an occasional mid-run reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom % 4 != 0)) begin
          set_src(i, ($urandom % 5 == 0) ? AW'(0) : AW'($urandom), {$urandom, $urandom});
        end
      end
      step($urandom % 6 == 0);
      if (c == 200) reset_async();
    end
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    step(0);
    step(0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) check($sformatf("rf_x%0d", i), rf_d[i], rf_m[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
